// File: rtl/obstacle_pool.sv
// Multi-slot obstacle manager: holds up to SLOTS obstacles in a fixed-point
// lane, scrolls them left on each game tick, frees them when they leave the
// screen, gates new spawns on the newest obstacle's trailing gap and freezes
// everything on crash.
module obstacle_pool #(
  parameter int SLOTS      = 4,
  parameter int FRAC       = 10,
  parameter int X_W        = 11,
  parameter int SPEED_W    = 15,
  parameter int W_W        = 10,
  parameter int GAP_W      = 11,
  parameter int GAME_WIDTH = 640
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         start,
  input  logic                         update,
  input  logic                         crash,
  input  logic [SPEED_W-1:0]           speed,
  input  logic                         spawn_valid,
  output logic                         spawn_ready,
  input  logic [W_W-1:0]               spawn_width,
  input  logic [GAP_W-1:0]             spawn_gap,
  input  logic signed [11:0]           spawn_offset,
  output logic [SLOTS-1:0]             slot_valid,
  output logic [SLOTS*X_W-1:0]         slot_x,
  output logic [SLOTS*W_W-1:0]         slot_width,
  output logic [SLOTS-1:0]             removed,
  output logic [$clog2(SLOTS+1)-1:0]   count,
  output logic                         full,
  output logic                         crashed
);

  localparam int OFF_W = 12;
  localparam int XG_W  = X_W + FRAC + 1;          // fixed-point lane position
  localparam int RM_W  = XG_W + W_W + 1;          // position plus scaled width
  localparam int PX_W  = X_W + W_W + GAP_W + 2;   // integer-pixel gap arithmetic
  localparam int CNT_W = $clog2(SLOTS + 1);
  localparam int IDX_W = $clog2(SLOTS);
  localparam logic signed [XG_W-1:0] SPAWN_X = XG_W'(GAME_WIDTH * (2 ** FRAC));

  typedef enum logic [1:0] {IDLE, RUNNING, CRASHED} state_e;

  state_e state_q, state_d;

  logic [SLOTS-1:0]              valid_q, valid_d;
  logic [SLOTS-1:0]              removed_q, removed_d;
  logic [SLOTS-1:0]              gone;
  logic signed [XG_W-1:0]        x_q [SLOTS];
  logic signed [XG_W-1:0]        x_d [SLOTS];
  logic signed [XG_W-1:0]        x_upd [SLOTS];
  logic signed [RM_W-1:0]        rm_sum [SLOTS];
  logic signed [X_W-1:0]         sx_q [SLOTS];
  logic signed [X_W-1:0]         sx_d [SLOTS];
  logic [W_W-1:0]                w_q [SLOTS];
  logic [W_W-1:0]                w_d [SLOTS];
  logic signed [OFF_W-1:0]       off_q [SLOTS];
  logic signed [OFF_W-1:0]       off_d [SLOTS];
  logic [IDX_W-1:0]              newest_idx_q, newest_idx_d;
  logic                          newest_valid_q, newest_valid_d;
  logic [GAP_W-1:0]              newest_gap_q, newest_gap_d;
  logic [CNT_W-1:0]              count_q, count_d;
  logic                          full_q, full_d;

  logic [IDX_W-1:0]              free_idx;
  logic signed [XG_W-1:0]        spd_ext;
  logic signed [PX_W-1:0]        newest_px, newest_wd, gap_px, room;
  logic                          gap_ok, upd_en, accept;

  // Lane state machine: clear beats crash beats everything else.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = RUNNING;
        RUNNING: if (crash) state_d = CRASHED;
        CRASHED: state_d = CRASHED;
        default: state_d = IDLE;
      endcase
    end
  end

  // Candidate motion per slot and scroll-off detection on the moved position.
  always_comb begin
    spd_ext = {{(XG_W-SPEED_W){1'b0}}, speed};
    for (int i = 0; i < SLOTS; i++) begin
      x_upd[i]  = x_q[i] - spd_ext + {{(XG_W-OFF_W){off_q[i][OFF_W-1]}}, off_q[i]};
      rm_sum[i] = {{(RM_W-XG_W){x_upd[i][XG_W-1]}}, x_upd[i]}
                + {{(RM_W-W_W-FRAC){1'b0}}, w_q[i], {FRAC{1'b0}}};
      gone[i]   = valid_q[i] && (rm_sum[i][RM_W-1] || (rm_sum[i] == '0));
    end
  end

  // Spawn gating: lowest free slot and trailing-gap check against the newest obstacle.
  always_comb begin
    free_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
    newest_px = {{(PX_W-X_W){sx_q[newest_idx_q][X_W-1]}}, sx_q[newest_idx_q]};
    newest_wd = {{(PX_W-W_W){1'b0}}, w_q[newest_idx_q]};
    gap_px    = {{(PX_W-GAP_W){1'b0}}, newest_gap_q};
    room      = PX_W'(GAME_WIDTH) - newest_px - newest_wd;
    gap_ok    = !newest_valid_q || (room >= gap_px);
  end

  assign spawn_ready = (state_q == RUNNING) && !full_q && gap_ok;
  assign upd_en      = (state_q == RUNNING) && update && !crash && !clear;
  assign accept      = spawn_valid && spawn_ready && !crash && !clear;

  // Slot next-state: move/free on tick, fill the lowest free slot on accept.
  always_comb begin
    valid_d        = valid_q;
    removed_d      = '0;
    newest_idx_d   = newest_idx_q;
    newest_valid_d = newest_valid_q;
    newest_gap_d   = newest_gap_q;
    for (int i = 0; i < SLOTS; i++) begin
      x_d[i]   = x_q[i];
      w_d[i]   = w_q[i];
      off_d[i] = off_q[i];
    end

    if (clear) begin
      valid_d        = '0;
      newest_valid_d = 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        x_d[i]   = '0;
        w_d[i]   = '0;
        off_d[i] = '0;
      end
    end else begin
      if (upd_en) begin
        for (int i = 0; i < SLOTS; i++) begin
          if (gone[i]) begin
            valid_d[i]   = 1'b0;
            removed_d[i] = 1'b1;
            x_d[i]       = '0;
            w_d[i]       = '0;
            off_d[i]     = '0;
          end else if (valid_q[i]) begin
            x_d[i] = x_upd[i];
          end
        end
        if (newest_valid_q && gone[newest_idx_q]) newest_valid_d = 1'b0;
      end
      if (accept) begin
        valid_d[free_idx] = 1'b1;
        x_d[free_idx]     = SPAWN_X;
        w_d[free_idx]     = spawn_width;
        off_d[free_idx]   = spawn_offset;
        newest_idx_d      = free_idx;
        newest_valid_d    = 1'b1;
        newest_gap_d      = spawn_gap;
      end
    end

    for (int i = 0; i < SLOTS; i++) begin
      sx_d[i] = X_W'(x_d[i] >>> FRAC);
    end
    count_d = '0;
    for (int i = 0; i < SLOTS; i++) begin
      count_d = count_d + CNT_W'(valid_d[i]);
    end
    full_d = &valid_d;
  end

  // State and slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: per-slot arrays are reset too, since their values are visible outputs right after reset.
    if (!rst_n) begin
      state_q        <= IDLE;
      valid_q        <= '0;
      removed_q      <= '0;
      newest_idx_q   <= '0;
      newest_valid_q <= 1'b0;
      newest_gap_q   <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        x_q[i]   <= '0;
        sx_q[i]  <= '0;
        w_q[i]   <= '0;
        off_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q        <= state_d;
      valid_q        <= valid_d;
      removed_q      <= removed_d;
      newest_idx_q   <= newest_idx_d;
      newest_valid_q <= newest_valid_d;
      newest_gap_q   <= newest_gap_d;
      count_q        <= count_d;
      full_q         <= full_d;
      for (int i = 0; i < SLOTS; i++) begin
        x_q[i]   <= x_d[i];
        sx_q[i]  <= sx_d[i];
        w_q[i]   <= w_d[i];
        off_q[i] <= off_d[i];
      end
    end
  end

  for (genvar g = 0; g < SLOTS; g++) begin : g_pack
    assign slot_x[g*X_W +: X_W]     = sx_q[g];
    assign slot_width[g*W_W +: W_W] = w_q[g];
  end

  assign slot_valid = valid_q;
  assign removed    = removed_q;
  assign count      = count_q;
  assign full       = full_q;
  assign crashed    = (state_q == CRASHED);

endmodule

// File: doc/obstacle_pool.md
Name: obstacle_pool

Overview:
- Parametrised multi-slot obstacle manager; successor to the single-obstacle controller.
- Holds up to SLOTS concurrent obstacles in a fixed-point horizontal lane, advances all of them on each game update pulse, and frees each one when it scrolls off the left edge.
- Gates new spawns on the newest obstacle's gap requirement and freezes the lane on crash.
- Sits between the obstacle-type/gap generator (upstream, valid/ready) and the renderer/collision logic (downstream, per-slot position buses).

Parameters:
- SLOTS, 4, number of obstacle slots (2..8).
- FRAC, 10, fractional bits of position and speed (speed scale = 2^FRAC).
- X_W, 11, signed integer pixel width of the slot_x outputs.
- SPEED_W, 15, unsigned speed input width.
- W_W, 10, obstacle width field.
- GAP_W, 11, gap field.
- GAME_WIDTH, 640, spawn x in pixels.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- clear  in  1  synchronous clear to IDLE, all slots freed.
- start  in  1  IDLE -> RUNNING.
- update  in  1  one-cycle game-tick pulse.
- crash  in  1  freeze lane.
- speed  in  SPEED_W  horizon speed, fixed point.
- spawn_valid  in  1  upstream offers an obstacle.
- spawn_ready  out  1  pool accepts this cycle.
- spawn_width  in  W_W  obstacle width in pixels.
- spawn_gap  in  GAP_W  required trailing gap in pixels.
- spawn_offset  in  12 signed  per-obstacle speed offset, fixed point.
- slot_valid  out  SLOTS  occupancy mask.
- slot_x  out  SLOTS*X_W  signed pixel x per slot; slot i at [i*X_W +: X_W].
- slot_width  out  SLOTS*W_W  width per slot.
- removed  out  SLOTS  one-cycle pulse per slot freed by scroll-off.
- count  out  $clog2(SLOTS+1)  popcount of slot_valid.
- full  out  1  all slots valid.
- crashed  out  1  state == CRASHED.

Behaviour:
- Reset (rst_n low, async): state IDLE; all slot_valid/removed/slot_x/slot_width/count/full/crashed = 0; spawn_ready = 0; newest_valid = 0.
- States:
  - IDLE -> RUNNING on start.
  - RUNNING -> CRASHED on crash.
  - CRASHED holds until clear.
  - clear from any state -> IDLE, all slots freed, removed stays 0.
  - Priority: clear > crash > start/update/spawn.
- Internal position: x_game per slot, signed, X_W+FRAC+1 bits.
  - slot_x = x_game >>> FRAC (arithmetic; floor toward -inf).
  - slot_x is registered and updates in the same edge as x_game.
- Update (RUNNING, update=1, no crash): every valid slot gets x_game <= x_game - speed + offset, computed at full width with no saturation.
- Removal: if the new x_game + (width << FRAC) <= 0, the slot is freed at that same edge, removed[i] pulses high for one cycle, and slot_x/slot_width clear to 0. Slots are freed only by scroll-off or clear.
- spawn_ready (combinational from registered state): RUNNING && !full && gap_ok.
  - gap_ok = !newest_valid || (GAME_WIDTH - (newest_x + newest_width)) >= newest_gap, evaluated as a signed comparison on integer pixels.
  - If the newest slot has been freed, newest_valid = 0 and gap_ok = 1.
- Accept (spawn_valid && spawn_ready):
  - Target is the lowest-index free slot.
  - x_game <= GAME_WIDTH << FRAC; width, gap and offset are captured.
  - That slot becomes newest and slot_valid rises on the next edge.
- Same-cycle spawn and update: the update applies only to previously valid slots; the new slot starts unmoved at GAME_WIDTH. A slot freed by that update is not reusable until the next cycle.
- Crash and update in the same cycle: crash wins, nothing moves, and spawn is not accepted.
- In CRASHED: positions are frozen and outputs hold; updates and spawns are ignored.
- count and full are registered and consistent with slot_valid.

Test Plan:
- Reset, start, spawn width=17 gap=120 speed=1024 offset=0: slot0 x=640, spawn_ready=0. After 136 updates x=504, spawn_ready=0. After the 137th update x=503, spawn_ready=1.
- Removal: speed=8192, width=17. After 82 updates x=-16, valid=1. On the 83rd update, removed[0] pulses one cycle; slot_valid=0 and count=0.
- Fixed point:
  - speed=1536: after 1 update slot_x=638, after 2 updates slot_x=637.
  - speed=1024, offset=+819: after 5 updates slot_x=638.
- Fill: SLOTS=4, gap=0, spawn_valid held. Slots 0..3 are filled on consecutive cycles, then full=1 and spawn_ready=0. Free slot1 via scroll-off; the next spawn lands in slot1.
- Crash: crash and update asserted together with 2 slots active. Positions are unchanged, crashed=1, and 10 further updates plus spawn_valid cause no change. clear gives slot_valid=0 and IDLE.
- Async reset with 3 slots active and rst_n pulsed low between clock edges: all outputs are 0 immediately, without waiting for a clock edge. start is required before spawn_ready can rise.
